// File: rtl/data_mem_mmio.sv
// Data-side memory stage for the single-cycle MIPS core.
// Holds a word-addressed data RAM with combinational reads, plus an MMIO window at
// 0xFFFF_xxxx containing a GPIO output register, a free-running cycle counter, a
// byte TX FIFO with a valid/ready drain port, and a status register with two sticky
// error bits (OVERFLOW and MISALIGN).
// Ports:
//   clock, reset          single clock; synchronous active-high reset
//   addr, write_data      byte address and store data from the core
//   mem_write             store strobe from the core
//   read_data             load data, combinational from addr
//   tx_data, tx_valid     FIFO head byte and non-empty flag
//   tx_ready              consumer accepts tx_data on this edge
//   gpio_out              GPIO_OUT register value
//   irq_err               OR of the two sticky error bits
module data_mem_mmio #(
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] gpio_out,
  output logic        irq_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [31:0]      ram [DEPTH];
  logic [7:0]       fifo [FIFO_DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [31:0]      gpio_q, cycle_q;
  logic             ovf_q, mis_q;

  // decode
  logic          is_mmio, misal, wr_ok;
  logic [AW-1:0] ram_idx;
  logic          sel_gpio, sel_cyc, sel_tx, sel_st;
  logic          empty, full, pop, push_req, push;
  logic          ovf_set, ovf_clr, mis_set, mis_clr;
  logic [31:0]   status;

  assign is_mmio  = (addr[31:16] == 16'hFFFF);
  assign misal    = |addr[1:0];
  assign wr_ok    = mem_write & ~misal;
  assign ram_idx  = addr[AW+1:2];  // upper bits ignored, so the RAM aliases

  assign sel_gpio = is_mmio && (addr[15:0] == 16'h0000);
  assign sel_cyc  = is_mmio && (addr[15:0] == 16'h0004);
  assign sel_tx   = is_mmio && (addr[15:0] == 16'h0008);
  assign sel_st   = is_mmio && (addr[15:0] == 16'h000C);

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign pop      = ~empty & tx_ready;
  assign push_req = wr_ok & sel_tx;
  // a full FIFO still takes a push when the head leaves on the same edge
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign ovf_clr  = wr_ok & sel_st & write_data[8];
  assign mis_set  = mem_write & misal;
  assign mis_clr  = wr_ok & sel_st & write_data[9];

  always_comb begin
    status            = '0;
    status[0]         = empty;
    status[1]         = full;
    status[2+:CNT_W]  = count;
    status[8]         = ovf_q;
    status[9]         = mis_q;
  end

  always_comb begin
    read_data = '0;
    if (!misal) begin
      if (!is_mmio)      read_data = ram[ram_idx];
      else if (sel_gpio) read_data = gpio_q;
      else if (sel_cyc)  read_data = cycle_q;
      else if (sel_st)   read_data = status;
    end
  end

  assign tx_valid = ~empty;
  assign tx_data  = fifo[rd_ptr];
  assign gpio_out = gpio_q;
  assign irq_err  = ovf_q | mis_q;

  // RAM has no reset and keeps writing through a reset edge
  always_ff @(posedge clock) begin
    if (wr_ok && !is_mmio) ram[ram_idx] <= write_data;
  end

  always_ff @(posedge clock) begin
    if (push && !reset) fifo[wr_ptr] <= write_data[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gpio_q  <= '0;
      cycle_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      ovf_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (wr_ok && sel_gpio) gpio_q <= write_data;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // set wins over a W1C clear on the same edge
      ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
      mis_q <= mis_set | (mis_q & ~mis_clr);
    end
  end
endmodule

// File: tb/tb_data_mem_mmio.sv
module tb_data_mem_mmio;
  localparam int DEPTH = 256;
  localparam int FD    = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0, write_data = '0;
  logic        mem_write = 1'b0, tx_ready = 1'b0;
  logic [31:0] read_data, gpio_out;
  logic [7:0]  tx_data;
  logic        tx_valid, irq_err;

  int n_tests = 0, n_fail = 0;

  data_mem_mmio #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clock(clock), .reset(reset), .addr(addr), .write_data(write_data),
    .mem_write(mem_write), .read_data(read_data), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .gpio_out(gpio_out),
    .irq_err(irq_err)
  );

  always #5 clock = ~clock;

  // behavioural model
  logic [31:0] m_ram [DEPTH];
  bit          m_vld [DEPTH];
  logic [7:0]  m_q [$];
  logic [31:0] m_gpio, m_cycle;
  bit          m_ovf, m_mis, m_known;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    return (32'(m_q.size()) << 2) | (m_q.size() == 0 ? 32'h1 : 32'h0) |
           (m_q.size() == FD ? 32'h2 : 32'h0) |
           (m_ovf ? 32'h100 : 32'h0) | (m_mis ? 32'h200 : 32'h0);
  endfunction

  function automatic void exp_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    int unsigned idx;
    idx = (a >> 2) % DEPTH;
    v = 0; known = 1;
    if (a % 4 != 0) v = 0;
    else if (a[31:16] != 16'hFFFF) begin
      known = m_vld[idx];
      v = m_ram[idx];
    end else if (a[15:0] == 16'h0) v = m_gpio;
    else if (a[15:0] == 16'h4) v = m_cycle;
    else if (a[15:0] == 16'hC) v = m_status();
  endfunction

  always @(posedge clock) begin
    bit al, mm, pop, clr_o, clr_m, set_o;
    int unsigned idx;
    al  = (addr % 4 == 0);
    mm  = (addr[31:16] == 16'hFFFF);
    idx = (addr >> 2) % DEPTH;
    if (mem_write && al && !mm) begin
      m_ram[idx] = write_data;
      m_vld[idx] = 1;
    end
    if (reset) begin
      m_gpio = 0; m_cycle = 0; m_q.delete(); m_ovf = 0; m_mis = 0; m_known = 1;
    end else if (m_known) begin
      m_cycle = m_cycle + 1;
      pop   = (m_q.size() != 0) && tx_ready;
      set_o = 0;
      clr_o = mem_write && al && mm && addr[15:0] == 16'hC && write_data[8];
      clr_m = mem_write && al && mm && addr[15:0] == 16'hC && write_data[9];
      if (pop) void'(m_q.pop_front());
      if (mem_write && al && mm && addr[15:0] == 16'h8) begin
        if (m_q.size() < FD) m_q.push_back(write_data[7:0]);
        else set_o = 1;
      end
      if (mem_write && al && mm && addr[15:0] == 16'h0) m_gpio = write_data;
      m_ovf = set_o || (m_ovf && !clr_o);
      m_mis = (mem_write && !al) || (m_mis && !clr_m);
    end
  end

  // per-cycle compare against the model
  always @(negedge clock) begin
    logic [31:0] e;
    bit k;
    if (m_known) begin
      exp_read(addr, e, k);
      if (k) chk("read_data", read_data, e);
      chk("gpio_out", gpio_out, m_gpio);
      chk("tx_valid", 32'(tx_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) chk("tx_data", 32'(tx_data), 32'(m_q[0]));
      chk("irq_err", 32'(irq_err), 32'(m_ovf || m_mis));
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask
  task automatic look();
    @(negedge clock);
  endtask
  task automatic set(input logic [31:0] a, input logic [31:0] wd, input logic we);
    addr = a; write_data = wd; mem_write = we;
  endtask

  initial begin
    logic [7:0] drain [4];
    logic [7:0] pushv [4];
    drain = '{8'h22, 8'h33, 8'h44, 8'h66};
    pushv = '{8'h11, 8'h22, 8'h33, 8'h44};

    tick(); tick();
    reset = 0;
    set(32'hFFFF000C, 0, 0);
    look();
    chk("rst_status", read_data, 32'h1);
    chk("rst_gpio", gpio_out, 0);
    chk("rst_valid", 32'(tx_valid), 0);
    chk("rst_irq", 32'(irq_err), 0);

    // counter
    set(32'hFFFF0004, 0, 0);
    repeat (10) tick();
    look(); chk("cycle10", read_data, 32'd10);
    set(32'hFFFF0004, 0, 1); tick();
    set(32'hFFFF0004, 0, 0); look(); chk("cycle_ro", read_data, 32'd11);

    // RAM
    set(32'h40, 32'hDEADBEEF, 1); tick();
    set(32'h40, 0, 0); look(); chk("ram_rd", read_data, 32'hDEADBEEF);
    tick();
    set(32'h40 + 4 * DEPTH, 0, 0); look(); chk("ram_alias", read_data, 32'hDEADBEEF);
    tick();
    set(32'h40, 32'h12345678, 1); look(); chk("ram_old", read_data, 32'hDEADBEEF);
    tick();
    set(32'h40, 0, 0); look(); chk("ram_new", read_data, 32'h12345678);

    // GPIO
    set(32'hFFFF0000, 32'hA5, 1); tick();
    set(32'hFFFF0000, 0, 0); look();
    chk("gpio_out", gpio_out, 32'hA5);
    chk("gpio_rd", read_data, 32'hA5);

    // FIFO fill, overflow, push+pop when full, drain
    tx_ready = 0;
    for (int i = 0; i < 4; i++) begin set(32'hFFFF0008, 32'(pushv[i]), 1); tick(); end
    set(32'hFFFF000C, 0, 0); look();
    chk("st_full", read_data, 32'h12);
    chk("head11", 32'(tx_data), 32'h11);
    set(32'hFFFF0008, 32'h55, 1); tick();
    set(32'hFFFF000C, 0, 0); look();
    chk("st_ovf", read_data, 32'h112);
    chk("irq_ovf", 32'(irq_err), 1);
    set(32'hFFFF0008, 32'h66, 1); tx_ready = 1; tick();
    set(32'hFFFF000C, 0, 0);
    for (int i = 0; i < 4; i++) begin
      look();
      if (i == 0) chk("st_pushpop", read_data, 32'h112);
      chk("drain_valid", 32'(tx_valid), 1);
      chk("drain_data", 32'(tx_data), 32'(drain[i]));
      tick();
    end
    look(); chk("drained", 32'(tx_valid), 0);
    tx_ready = 0;

    // misaligned store and W1C
    set(32'h41, 32'hFFFFFFFF, 1); tick();
    set(32'h40, 0, 0); look(); chk("mis_ram", read_data, 32'h12345678);
    tick();
    set(32'hFFFF000C, 0, 0); look(); chk("st_mis", read_data, 32'h301);
    set(32'hFFFF000C, 32'h300, 1); tick();
    set(32'hFFFF000C, 0, 0); look();
    chk("st_w1c", read_data, 32'h1);
    chk("irq_clr", 32'(irq_err), 0);
    set(32'hFFFF000D, 32'h300, 1); tick();
    set(32'hFFFF000C, 0, 0); look(); chk("st_mis_w1c", read_data, 32'h201);
    set(32'hFFFF000C, 32'h200, 1); tick();

    // reset mid-operation
    for (int i = 1; i <= 3; i++) begin set(32'hFFFF0008, i, 1); tick(); end
    reset = 1;
    set(32'hFFFF0008, 32'h77, 1); tick();
    set(32'h80, 32'hCAFEF00D, 1); tick();
    reset = 0;
    set(32'hFFFF0004, 0, 0); look();
    chk("rr_cycle", read_data, 0);
    chk("rr_gpio", gpio_out, 0);
    chk("rr_valid", 32'(tx_valid), 0);
    tick();
    set(32'hFFFF000C, 0, 0); look(); chk("rr_status", read_data, 32'h1);
    tick();
    set(32'h80, 0, 0); look(); chk("rr_ram80", read_data, 32'hCAFEF00D);
    tick();
    set(32'h40, 0, 0); look(); chk("rr_ram40", read_data, 32'h12345678);
    tick();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 15);
      case (k)
        0, 1, 2, 3, 4: a = 32'hFFFF0008;
        5:  a = 32'hFFFF000C;
        6:  a = 32'hFFFF0000;
        7:  a = 32'hFFFF0004;
        8:  a = 32'hFFFF0010 + 4 * $urandom_range(0, 3);
        9:  a = 32'hFFFF0000 | ($urandom_range(0, 3) << 2) | $urandom_range(1, 3);
        default: a = ($urandom_range(0, 16'hFFFE) << 16) | ($urandom_range(0, 3) << 10) |
                     ($urandom_range(0, 15) << 2) | ($urandom_range(0, 7) == 0 ? $urandom_range(1, 3) : 0);
      endcase
      set(a, $urandom, 1'($urandom_range(0, 1)));
      tx_ready = ($urandom_range(0, 2) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 0; set(0, 0, 0); tx_ready = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
